// File: rtl/itch_pkg.sv
// Shared definitions for the ITCH ingress framing stages: framer states,
// common message type bytes and the default body-length limit.
package itch_pkg;

    typedef enum logic [1:0] {
        ST_LEN  = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam logic [7:0] ITCH_ADD_ORDER = 8'h41;  // 'A'
    localparam logic [7:0] ITCH_EXECUTED  = 8'h45;  // 'E'
    localparam logic [7:0] ITCH_CANCEL    = 8'h58;  // 'X'
    localparam logic [7:0] ITCH_DELETE    = 8'h44;  // 'D'

    localparam int DEFAULT_MAX_MSG_LEN = 64;

endpackage

// File: rtl/itch_msg_framer_if.sv
// Stream bundle between TCP reassembly, the framer and the payload decoders.
// The framer takes the slave view; the upstream driver takes the master view.
interface itch_msg_framer_if #(
    parameter int IDX_W = 8
);
    logic [7:0]       tcp_payload_in;
    logic             tcp_byte_valid_in;
    logic [7:0]       payload_out;
    logic             payload_valid_out;
    logic             start_flag;
    logic             end_flag;
    logic [IDX_W-1:0] byte_index;
    logic [7:0]       msg_type;
    logic [IDX_W-1:0] msg_len_out;
    logic             len_err;
    logic             abort;

    modport slave (
        input  tcp_payload_in, tcp_byte_valid_in,
        output payload_out, payload_valid_out, start_flag, end_flag,
               byte_index, msg_type, msg_len_out, len_err, abort
    );

    modport master (
        output tcp_payload_in, tcp_byte_valid_in,
        input  payload_out, payload_valid_out, start_flag, end_flag,
               byte_index, msg_type, msg_len_out, len_err, abort
    );
endinterface

// File: rtl/itch_idle_timer.sv
// Saturating idle counter: counts enabled cycles, clears on request and
// pulses expire_o in the cycle the count reaches TIMEOUT_CYCLES (0 = never).
module itch_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/itch_msg_framer.sv
// Strips the big-endian length prefix from an ITCH byte stream and forwards
// each message body with start/end flags, byte index, length and type.
module itch_msg_framer
    import itch_pkg::*;
#(
    parameter int LEN_BYTES      = 2,
    parameter int MAX_MSG_LEN    = DEFAULT_MAX_MSG_LEN,
    parameter int IDX_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                clk,
    input logic                rst_n,
    itch_msg_framer_if.slave   bus
);
    localparam int LW = 8 * LEN_BYTES;
    localparam logic [LW-1:0] MAX_L    = LW'(MAX_MSG_LEN);
    localparam logic [2:0]    LAST_LEN = 3'(LEN_BYTES - 1);

    state_e           state_q, state_d;
    logic [2:0]       len_cnt_q, len_cnt_d;
    logic [LW-1:0]    acc_q, acc_d, acc_shift;
    logic [LW-1:0]    rem_q, rem_d;
    logic [7:0]       payload_q, payload_d, type_q, type_d;
    logic [IDX_W-1:0] idx_q, idx_d, mlen_q, mlen_d;
    logic             valid_q, valid_d, start_q, start_d, end_q, end_d;
    logic             err_q, err_d, abort_q, abort_d;
    logic             in_msg, expire;

    // A message is "open" once any prefix byte has arrived; only then can it stall.
    assign in_msg = (state_q != ST_LEN) || (len_cnt_q != 3'd0);

    itch_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (in_msg && !bus.tcp_byte_valid_in),
        .clr_i    (bus.tcp_byte_valid_in || !in_msg),
        .expire_o (expire)
    );

    assign acc_shift = (acc_q << 8) | LW'(bus.tcp_payload_in);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        len_cnt_d = len_cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        payload_d = payload_q;
        type_d    = type_q;
        idx_d     = idx_q;
        mlen_d    = mlen_q;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        end_d     = 1'b0;
        err_d     = 1'b0;
        abort_d   = 1'b0;

        if (bus.tcp_byte_valid_in) begin
            unique case (state_q)
                ST_LEN: begin
                    acc_d     = acc_shift;
                    len_cnt_d = len_cnt_q + 3'd1;
                    if (len_cnt_q == LAST_LEN) begin
                        acc_d     = '0;
                        len_cnt_d = 3'd0;
                        rem_d     = acc_shift;
                        if (acc_shift == '0) begin
                            err_d = 1'b1;
                        end else if (acc_shift > MAX_L) begin
                            err_d   = 1'b1;
                            state_d = ST_DROP;
                        end else begin
                            state_d = ST_BODY;
                            mlen_d  = IDX_W'(acc_shift);
                        end
                    end
                end
                ST_BODY: begin
                    valid_d   = 1'b1;
                    payload_d = bus.tcp_payload_in;
                    idx_d     = mlen_q - IDX_W'(rem_q);
                    rem_d     = rem_q - LW'(1);
                    if (rem_q == LW'(mlen_q)) begin
                        start_d = 1'b1;
                        type_d  = bus.tcp_payload_in;
                    end
                    if (rem_q == LW'(1)) begin
                        end_d   = 1'b1;
                        state_d = ST_LEN;
                    end
                end
                ST_DROP: begin
                    rem_d = rem_q - LW'(1);
                    if (rem_q == LW'(1)) state_d = ST_LEN;
                end
                default: state_d = ST_LEN;
            endcase
        end else if (expire) begin
            abort_d   = 1'b1;
            state_d   = ST_LEN;
            len_cnt_d = 3'd0;
            acc_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LEN;
            len_cnt_q <= 3'd0;
            acc_q     <= '0;
            rem_q     <= '0;
            payload_q <= '0;
            type_q    <= '0;
            idx_q     <= '0;
            mlen_q    <= '0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_cnt_q <= len_cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            payload_q <= payload_d;
            type_q    <= type_d;
            idx_q     <= idx_d;
            mlen_q    <= mlen_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            end_q     <= end_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.payload_out       = payload_q;
    assign bus.payload_valid_out = valid_q;
    assign bus.start_flag        = start_q;
    assign bus.end_flag          = end_q;
    assign bus.byte_index        = idx_q;
    assign bus.msg_type          = type_q;
    assign bus.msg_len_out       = mlen_q;
    assign bus.len_err           = err_q;
    assign bus.abort             = abort_q;
endmodule

// File: tb/tb_itch_msg_framer.sv
// Directed bench for itch_msg_framer: a vector table for contiguous framing,
// plus hand sequences for drop, gaps, timeout abort and mid-message reset.
module tb_itch_msg_framer;
    import itch_pkg::*;

    localparam int TO = 1024;

    typedef struct {
        logic       vld;
        logic [7:0] din;
        logic       ev;
        logic [7:0] data;
        logic [7:0] idx;
        logic       st;
        logic       en;
        logic [7:0] typ;
        logic [7:0] len;
        logic       err;
        logic       ab;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;

    itch_msg_framer_if #(.IDX_W(8)) bus ();

    itch_msg_framer #(
        .LEN_BYTES(2), .MAX_MSG_LEN(64), .IDX_W(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic vld, logic [7:0] din, logic ev, logic [7:0] data,
                                logic [7:0] idx, logic st, logic en, logic [7:0] typ,
                                logic [7:0] len, logic err, logic ab);
        vec_t v;
        v.vld = vld; v.din = din; v.ev = ev; v.data = data; v.idx = idx;
        v.st = st; v.en = en; v.typ = typ; v.len = len; v.err = err; v.ab = ab;
        return v;
    endfunction

    // Idle/non-payload vector: no outputs except held type and length.
    function automatic vec_t nop(logic vld, logic [7:0] din, logic [7:0] typ, logic [7:0] len);
        return mk(vld, din, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, typ, len, 1'b0, 1'b0);
    endfunction

    task automatic check(input string name, input logic [44:0] act, input logic [44:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got v/s/e/err/ab=%b data=%h idx=%0d type=%h len=%0d, want v/s/e/err/ab=%b data=%h idx=%0d type=%h len=%0d",
                     name, act[44:40], act[39:32], act[31:24], act[23:16], act[15:8],
                     exp[44:40], exp[39:32], exp[31:24], exp[23:16], exp[15:8]);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        logic [44:0] act, exp;
        bus.tcp_byte_valid_in = v.vld;
        bus.tcp_payload_in    = v.din;
        @(posedge clk);
        #1;
        act = {bus.payload_valid_out, bus.start_flag, bus.end_flag, bus.len_err, bus.abort,
               bus.payload_out, bus.byte_index, bus.msg_type, bus.msg_len_out, 8'h00};
        exp = {v.ev, v.st, v.en, v.err, v.ab, v.data, v.idx, v.typ, v.len, 8'h00};
        if (!v.ev) act[39:24] = 16'h0000;
        check(name, act, exp);
    endtask

    vec_t table_q[$];

    initial begin
        bus.tcp_byte_valid_in = 1'b0;
        bus.tcp_payload_in    = 8'h00;

        // 00 03 41 11 22
        table_q.push_back(nop(1, 8'h00, 8'h00, 8'd0));
        table_q.push_back(nop(1, 8'h03, 8'h00, 8'd3));
        table_q.push_back(mk(1, 8'h41, 1, 8'h41, 8'd0, 1, 0, 8'h41, 8'd3, 0, 0));
        table_q.push_back(mk(1, 8'h11, 1, 8'h11, 8'd1, 0, 0, 8'h41, 8'd3, 0, 0));
        table_q.push_back(mk(1, 8'h22, 1, 8'h22, 8'd2, 0, 1, 8'h41, 8'd3, 0, 0));
        // 00 01 58 then 00 02 44 99, no bubbles
        table_q.push_back(nop(1, 8'h00, 8'h41, 8'd3));
        table_q.push_back(nop(1, 8'h01, 8'h41, 8'd1));
        table_q.push_back(mk(1, 8'h58, 1, 8'h58, 8'd0, 1, 1, 8'h58, 8'd1, 0, 0));
        table_q.push_back(nop(1, 8'h00, 8'h58, 8'd1));
        table_q.push_back(nop(1, 8'h02, 8'h58, 8'd2));
        table_q.push_back(mk(1, 8'h44, 1, 8'h44, 8'd0, 1, 0, 8'h44, 8'd2, 0, 0));
        table_q.push_back(mk(1, 8'h99, 1, 8'h99, 8'd1, 0, 1, 8'h44, 8'd2, 0, 0));
        // idle in LEN, then zero length, then 00 02 41 42 with a prefix gap
        table_q.push_back(nop(0, 8'hFF, 8'h44, 8'd2));
        table_q.push_back(nop(1, 8'h00, 8'h44, 8'd2));
        table_q.push_back(mk(1, 8'h00, 0, 8'h00, 8'd0, 0, 0, 8'h44, 8'd2, 1, 0));
        table_q.push_back(nop(1, 8'h00, 8'h44, 8'd2));
        table_q.push_back(nop(0, 8'h77, 8'h44, 8'd2));
        table_q.push_back(nop(1, 8'h02, 8'h44, 8'd2));
        table_q.push_back(mk(1, 8'h41, 1, 8'h41, 8'd0, 1, 0, 8'h41, 8'd2, 0, 0));
        table_q.push_back(mk(1, 8'h42, 1, 8'h42, 8'd1, 0, 1, 8'h41, 8'd2, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.payload_valid_out, bus.start_flag, bus.end_flag, bus.len_err,
              bus.abort, bus.payload_out, bus.byte_index, bus.msg_type, bus.msg_len_out, 8'h00}, 45'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (table_q[i]) apply($sformatf("table[%0d]", i), table_q[i]);

        // Oversize length 00 50: 80 bytes dropped, then 00 01 41
        apply("drop_len0", nop(1, 8'h00, 8'h41, 8'd2));
        apply("drop_len1", mk(1, 8'h50, 0, 8'h00, 8'd0, 0, 0, 8'h41, 8'd2, 1, 0));
        for (int i = 0; i < 80; i++)
            apply($sformatf("drop_byte[%0d]", i), nop(1, 8'(i + 1), 8'h41, 8'd2));
        apply("after_drop_len0", nop(1, 8'h00, 8'h41, 8'd2));
        apply("after_drop_len1", nop(1, 8'h01, 8'h41, 8'd1));
        apply("after_drop_body", mk(1, ITCH_ADD_ORDER, 1, 8'h41, 8'd0, 1, 1, 8'h41, 8'd1, 0, 0));

        // 00 04 41 11, 10-cycle gap, 22 33
        apply("gap_len0", nop(1, 8'h00, 8'h41, 8'd1));
        apply("gap_len1", nop(1, 8'h04, 8'h41, 8'd4));
        apply("gap_b0", mk(1, 8'h41, 1, 8'h41, 8'd0, 1, 0, 8'h41, 8'd4, 0, 0));
        apply("gap_b1", mk(1, 8'h11, 1, 8'h11, 8'd1, 0, 0, 8'h41, 8'd4, 0, 0));
        for (int i = 0; i < 10; i++) apply($sformatf("gap_idle[%0d]", i), nop(0, 8'hEE, 8'h41, 8'd4));
        apply("gap_b2", mk(1, 8'h22, 1, 8'h22, 8'd2, 0, 0, 8'h41, 8'd4, 0, 0));
        apply("gap_b3", mk(1, 8'h33, 1, 8'h33, 8'd3, 0, 1, 8'h41, 8'd4, 0, 0));

        // 00 04 41 then TIMEOUT idle cycles: abort on the last, no end_flag
        apply("to_len0", nop(1, 8'h00, 8'h41, 8'd4));
        apply("to_len1", nop(1, 8'h04, 8'h41, 8'd4));
        apply("to_b0", mk(1, 8'h41, 1, 8'h41, 8'd0, 1, 0, 8'h41, 8'd4, 0, 0));
        for (int i = 0; i < TO - 1; i++) apply("to_idle", nop(0, 8'h00, 8'h41, 8'd4));
        apply("to_abort", mk(0, 8'h00, 0, 8'h00, 8'd0, 0, 0, 8'h41, 8'd4, 0, 1));
        apply("to_after", nop(0, 8'h00, 8'h41, 8'd4));
        apply("to_next_len0", nop(1, 8'h00, 8'h41, 8'd4));
        apply("to_next_len1", nop(1, 8'h01, 8'h41, 8'd1));
        apply("to_next_body", mk(1, ITCH_EXECUTED, 1, 8'h45, 8'd0, 1, 1, 8'h45, 8'd1, 0, 0));

        // Reset in the middle of 00 03 41 ..
        apply("rst_len0", nop(1, 8'h00, 8'h45, 8'd1));
        apply("rst_len1", nop(1, 8'h03, 8'h45, 8'd3));
        apply("rst_b0", mk(1, 8'h41, 1, 8'h41, 8'd0, 1, 0, 8'h41, 8'd3, 0, 0));
        bus.tcp_byte_valid_in = 1'b1;
        bus.tcp_payload_in    = 8'h11;
        rst_n = 1'b0;
        #1;
        check("rst_midbody", {bus.payload_valid_out, bus.start_flag, bus.end_flag, bus.len_err,
              bus.abort, bus.payload_out, bus.byte_index, bus.msg_type, bus.msg_len_out, 8'h00}, 45'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst_len0", nop(1, 8'h00, 8'h00, 8'd0));
        apply("post_rst_len1", nop(1, 8'h01, 8'h00, 8'd1));
        apply("post_rst_body", mk(1, ITCH_DELETE, 1, 8'h44, 8'd0, 1, 1, 8'h44, 8'd1, 0, 0));
        apply("post_rst_idle", nop(0, 8'h00, 8'h44, 8'd1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
